// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
// Holds the controller state encoding and the entry-count helper.
package regfile_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_DEPTH   = 8;
  localparam int unsigned DEFAULT_WIDTH   = 16;
  localparam int unsigned DEFAULT_NUM_REQ = 2;

  // Number of regfile entries addressed by a DEPTH-bit address.
  function automatic int unsigned entry_count(input int unsigned depth);
    return 32'd1 << depth;
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Requester-side bus of the register-file access controller: flattened
// per-requester request fields plus the shared registered read response.
interface regfile_req_if #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_we;
  logic [NUM_REQ*DEPTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/regfile_access_ctrl_arb.sv
// One-hot request arbiter. REGFILE_CTRL_RR_EN selects round-robin with a
// pointer that advances past each accepted winner; otherwise lowest index wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
`ifdef REGFILE_CTRL_RR_EN
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
`endif
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant
);

`ifdef REGFILE_CTRL_RR_EN
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  int               idx;

  // NOTE: every variable driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_next   = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments and a synchronous,
  // active-high reset sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_next;
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_access_ctrl.sv
// Shares a 1W/1R register file among NUM_REQ requesters and sequences a bulk
// zero-clear. Arbitration mode is selected by the REGFILE_CTRL_RR_EN macro.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  regfile_req_if.slave     bus,
  input  logic             clear_start,
  output logic             busy,
  output logic             clear_done,
  output logic [DEPTH-1:0] rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             rf_we,
  output logic [DEPTH-1:0] rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata
);

  localparam int unsigned      ENTRIES   = entry_count(DEPTH);
  localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(ENTRIES - 1);

  state_t               state;
  state_t               state_next;
  logic [DEPTH-1:0]     clr_cnt;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   rd_grant;
  logic                 win_we;
  logic [DEPTH-1:0]     win_addr;
  logic [WIDTH-1:0]     win_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
`ifdef REGFILE_CTRL_RR_EN
    .clk     (clk),
    .reset   (reset),
    .advance (|grant),
`endif
    .req     (bus.req_valid),
    .grant   (arb_grant)
  );

  // Select the winning requester's fields; the arbiter grant is one-hot.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_we    = bus.req_we[i];
        win_addr  = bus.req_addr[i*DEPTH +: DEPTH];
        win_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs are gated by reset so a reset landing mid-clear suppresses the
  // write of the current address instead of completing it.
  always_comb begin
    state_next = state;
    grant      = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    rf_raddr   = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state_next = CLEAR;
          end else begin
            grant = arb_grant;
            if (|arb_grant) begin
              if (win_we) begin
                rf_we    = 1'b1;
                rf_waddr = win_addr;
                rf_wdata = win_wdata;
              end else begin
                rf_raddr = win_addr;
              end
            end
          end
        end
        CLEAR: begin
          rf_we    = 1'b1;
          rf_waddr = clr_cnt;
          if (clr_cnt == LAST_ADDR) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign rd_grant      = (|grant && !win_we) ? grant : '0;
  assign busy          = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      clear_done    <= 1'b0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      state         <= state_next;
      clr_cnt       <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
      clear_done    <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
      bus.rsp_valid <= rd_grant;
      if (|rd_grant) begin
        bus.rsp_rdata <= rf_rdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural regfile; read
// responses are checked by a scoreboard monitor. Honours REGFILE_CTRL_RR_EN.
module tb_regfile_access_ctrl;

  localparam int DEPTH   = 4;
  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 2;

  typedef struct {
    logic [NUM_REQ-1:0] who;
    logic [WIDTH-1:0]   data;
    int                 due;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             clear_start;
  logic             busy;
  logic             clear_done;
  logic [DEPTH-1:0] rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic             rf_we;
  logic [DEPTH-1:0] rf_raddr;
  logic [WIDTH-1:0] rf_rdata;

  logic [WIDTH-1:0] mem [2**DEPTH];
  exp_t             exp_q [$];
  int               checks;
  int               errors;
  int               cyc_cnt;

  regfile_req_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  regfile_access_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear_start (clear_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_we       (rf_we),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata)
  );

  // Behavioural regfile: synchronous write, combinational read, no reset.
  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = mem[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_rsp(input logic [NUM_REQ-1:0] who, input logic [WIDTH-1:0] data);
    exp_t e;
    e.who  = who;
    e.data = data;
    e.due  = cyc_cnt + 1;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_valid", 32'(bus.rsp_valid), 32'(e.who));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
        check("rsp_latency", 32'(cyc_cnt), 32'(e.due));
      end
    end
  end

  task automatic idle_bus();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic wr(input int idx, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    idle_bus();
    bus.req_valid[idx]               = 1'b1;
    bus.req_we[idx]                  = 1'b1;
    bus.req_addr[idx*DEPTH +: DEPTH] = a;
    bus.req_wdata[idx*WIDTH +: WIDTH] = d;
    #1;
  endtask

  task automatic rd(input int idx, input logic [DEPTH-1:0] a, input logic [WIDTH-1:0] d);
    logic [NUM_REQ-1:0] who;
    @(negedge clk);
    idle_bus();
    who                              = '0;
    who[idx]                         = 1'b1;
    bus.req_valid[idx]               = 1'b1;
    bus.req_addr[idx*DEPTH +: DEPTH] = a;
    expect_rsp(who, d);
    #1;
    check("rd_ready", 32'(bus.req_ready), 32'(who));
    check("rd_raddr", 32'(rf_raddr), 32'(a));
  endtask

  task automatic preload(input logic [WIDTH-1:0] d);
    for (int a = 0; a < 2**DEPTH; a++) wr(0, DEPTH'(a), d);
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] exp_g;
    int                 busy_cnt;
    bit                 done;

    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    clear_start = 1'b0;
    idle_bus();

    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("reset_clear_done", 32'(clear_done), 32'h0);
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_rf_we", 32'(rf_we), 32'h0);
    check("idle_rf_waddr", 32'(rf_waddr), 32'h0);

    // Write then read back on the next cycle.
    wr(0, 4'd3, 16'hBEEF);
    check("wr_ready", 32'(bus.req_ready), 32'h1);
    check("wr_rf_we", 32'(rf_we), 32'h1);
    check("wr_rf_waddr", 32'(rf_waddr), 32'h3);
    check("wr_rf_wdata", 32'(rf_wdata), 32'hBEEF);
    rd(0, 4'd3, 16'hBEEF);
    wr(1, 4'd5, 16'h1234);
    check("wr1_ready", 32'(bus.req_ready), 32'h2);
    rd(1, 4'd5, 16'h1234);
    @(negedge clk);
    idle_bus();

    // Contention: req0 writes addr 1, req1 reads addr 1, both held valid.
    bus.req_valid              = 2'b11;
    bus.req_we                 = 2'b01;
    bus.req_addr               = {4'd1, 4'd1};
    bus.req_wdata[0 +: WIDTH]  = 16'hA5A5;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
`ifdef REGFILE_CTRL_RR_EN
      exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      if (exp_g == 2'b10) expect_rsp(2'b10, 16'hA5A5);
      #1;
      check("contend_grant", 32'(bus.req_ready), 32'(exp_g));
    end
    @(negedge clk);
    bus.req_valid = 2'b10;
    expect_rsp(2'b10, 16'hA5A5);
    #1;
    check("alone_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    idle_bus();

    // Bulk clear with clear_start colliding with two requests.
    preload(16'h1111);
    @(negedge clk);
    clear_start   = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_addr  = {4'd7, 4'd7};
    #1;
    check("clr_start_ready", 32'(bus.req_ready), 32'h0);
    check("clr_start_rf_we", 32'(rf_we), 32'h0);
    check("clr_start_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clear_start = 1'b0;
    busy_cnt    = 0;
    done        = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (busy) begin
        check("clr_ready", 32'(bus.req_ready), 32'h0);
        check("clr_rf_we", 32'(rf_we), 32'h1);
        check("clr_waddr", 32'(rf_waddr), 32'(busy_cnt));
        check("clr_wdata", 32'(rf_wdata), 32'h0);
        check("clr_done_early", 32'(clear_done), 32'h0);
        clear_start = (busy_cnt == 3);
        busy_cnt++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    clear_start = 1'b0;
    check("clr_length", 32'(busy_cnt), 32'd16);
    check("clr_done_pulse", 32'(clear_done), 32'h1);
`ifdef REGFILE_CTRL_RR_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    check("post_clr_grant", 32'(bus.req_ready), 32'(exp_g));
    expect_rsp(exp_g, 16'h0000);
    @(negedge clk);
    idle_bus();
    #1;
    check("clr_done_once", 32'(clear_done), 32'h0);
    check("post_clr_busy", 32'(busy), 32'h0);
    rd(0, 4'd0, 16'h0000);
    rd(0, 4'd9, 16'h0000);
    rd(0, 4'd15, 16'h0000);
    @(negedge clk);
    idle_bus();

    // Reset in clear cycle 5 aborts the clear; entries 5..15 keep old data.
    preload(16'h2222);
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("abort_waddr", 32'(rf_waddr), 32'h5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("abort_clear_done", 32'(clear_done), 32'h0);
    @(negedge clk);
    #1;
    check("abort_no_done", 32'(clear_done), 32'h0);
    rd(0, 4'd4, 16'h0000);
    rd(0, 4'd5, 16'h2222);
    rd(1, 4'd15, 16'h2222);
    @(negedge clk);
    idle_bus();

    repeat (4) @(negedge clk);
    check("rsp_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
